// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the instruction-fetch / load-store memory arbiter:
//   - FSM state encodings (IDLE=0, ISSUE=1, WAIT=2)
//   - transaction owner encodings (OWN_IF=0, OWN_D=1)
//   - default memory latency and starvation limit
//   - cnt_width(): bits needed for a counter that must hold 0..max_val
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_STARVE_MAX = 4;

    // Never returns less than 1 so degenerate parameters still give a legal vector.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Winner selection between the fetch and data requesters, plus the
// saturating starvation counter that guarantees fetch progress.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (clears starve count)
//   if_req   in   fetch request level
//   d_req    in   data request level
//   take     in   the arbiter is accepting the current winner this cycle
//   pick_d   out  1 = data wins, 0 = fetch wins (combinational)
//   any_req  out  at least one request is pending (combinational)
// ---------------------------------------------------------------------------
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic take,
    output logic pick_d,
    output logic any_req
);

    localparam int SCW = cnt_width(STARVE_MAX);

    logic [SCW-1:0] r_starve_cnt;
    logic [SCW-1:0] r_starve_cnt_next;
    logic           w_starved;

    assign w_starved = (r_starve_cnt == SCW'(STARVE_MAX));
    // Data has priority unless fetch has already waited through STARVE_MAX data wins.
    assign pick_d    = d_req && !(if_req && w_starved);
    assign any_req   = if_req | d_req;

    always_comb begin
        r_starve_cnt_next = r_starve_cnt;
        if (take) begin
            if (!pick_d) begin
                r_starve_cnt_next = '0;
            end else if (if_req && !w_starved) begin
                // Only a data win that actually made fetch wait counts.
                r_starve_cnt_next = r_starve_cnt + SCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= r_starve_cnt_next;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Serialises fetch and load/store accesses onto one synchronous memory with
// fixed read latency; one transaction in flight at a time. All outputs are
// registered and reset to 0.
//
// Ports:
//   clk, rst                    clock / synchronous active-high reset
//   if_req, if_addr             fetch request and address
//   if_gnt, if_rvalid, if_rdata fetch accept pulse, completion pulse, data
//   d_req, d_we, d_addr,
//   d_wdata, d_be               data request, write flag, address, data, strobes
//   d_gnt, d_rvalid, d_rdata    data accept pulse, completion pulse, read data
//   mem_en, mem_we, mem_be,
//   mem_addr, mem_wdata         memory command (mem_en is a 1-cycle strobe)
//   mem_rdata                   memory read data, MEM_LAT cycles after mem_en
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int BW  = DW / 8;
    localparam int WCW = cnt_width(MEM_LAT - 1);

    state_t         r_state,     r_state_next;
    owner_t         r_owner,     r_owner_next;
    logic [WCW-1:0] r_wait_cnt,  r_wait_cnt_next;
    logic           r_if_gnt,    r_if_gnt_next;
    logic           r_d_gnt,     r_d_gnt_next;
    logic           r_if_rvalid, r_if_rvalid_next;
    logic           r_d_rvalid,  r_d_rvalid_next;
    logic [DW-1:0]  r_if_rdata,  r_if_rdata_next;
    logic [DW-1:0]  r_d_rdata,   r_d_rdata_next;
    logic           r_mem_en,    r_mem_en_next;
    logic           r_mem_we,    r_mem_we_next;
    logic [BW-1:0]  r_mem_be,    r_mem_be_next;
    logic [AW-1:0]  r_mem_addr,  r_mem_addr_next;
    logic [DW-1:0]  r_mem_wdata, r_mem_wdata_next;

    logic w_take;
    logic w_pick_d;
    logic w_any_req;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .d_req   (d_req),
        .take    (w_take),
        .pick_d  (w_pick_d),
        .any_req (w_any_req)
    );

    always_comb begin
        r_state_next     = r_state;
        r_owner_next     = r_owner;
        r_wait_cnt_next  = r_wait_cnt;
        r_if_gnt_next    = 1'b0;
        r_d_gnt_next     = 1'b0;
        r_if_rvalid_next = 1'b0;
        r_d_rvalid_next  = 1'b0;
        r_if_rdata_next  = r_if_rdata;
        r_d_rdata_next   = r_d_rdata;
        r_mem_en_next    = 1'b0;
        r_mem_we_next    = r_mem_we;
        r_mem_be_next    = r_mem_be;
        r_mem_addr_next  = r_mem_addr;
        r_mem_wdata_next = r_mem_wdata;
        w_take           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Outputs are registered, so the command and grant are set up
                // here and become visible during the ISSUE cycle.
                if (w_any_req) begin
                    w_take        = 1'b1;
                    r_mem_en_next = 1'b1;
                    r_state_next  = ST_ISSUE;
                    if (w_pick_d) begin
                        r_owner_next     = OWN_D;
                        r_d_gnt_next     = 1'b1;
                        r_mem_we_next    = d_we;
                        r_mem_be_next    = d_be;
                        r_mem_addr_next  = d_addr;
                        r_mem_wdata_next = d_wdata;
                    end else begin
                        r_owner_next     = OWN_IF;
                        r_if_gnt_next    = 1'b1;
                        r_mem_we_next    = 1'b0;
                        r_mem_be_next    = '1;
                        r_mem_addr_next  = if_addr;
                        r_mem_wdata_next = '0;
                    end
                end
            end
            ST_ISSUE: begin
                r_wait_cnt_next = WCW'(MEM_LAT - 1);
                r_state_next    = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_wait_cnt == '0) begin
                    // mem_rdata is valid now; the response appears next cycle,
                    // which is also the next IDLE cycle.
                    r_state_next = ST_IDLE;
                    if (r_owner == OWN_D) begin
                        r_d_rvalid_next = 1'b1;
                        if (!r_mem_we) begin
                            r_d_rdata_next = mem_rdata;
                        end
                    end else begin
                        r_if_rvalid_next = 1'b1;
                        r_if_rdata_next  = mem_rdata;
                    end
                end else begin
                    r_wait_cnt_next = r_wait_cnt - WCW'(1);
                end
            end
            default: begin
                r_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_IF;
            r_wait_cnt  <= '0;
            r_if_gnt    <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= r_state_next;
            r_owner     <= r_owner_next;
            r_wait_cnt  <= r_wait_cnt_next;
            r_if_gnt    <= r_if_gnt_next;
            r_d_gnt     <= r_d_gnt_next;
            r_if_rvalid <= r_if_rvalid_next;
            r_d_rvalid  <= r_d_rvalid_next;
            r_if_rdata  <= r_if_rdata_next;
            r_d_rdata   <= r_d_rdata_next;
            r_mem_en    <= r_mem_en_next;
            r_mem_we    <= r_mem_we_next;
            r_mem_be    <= r_mem_be_next;
            r_mem_addr  <= r_mem_addr_next;
            r_mem_wdata <= r_mem_wdata_next;
        end
    end

    assign if_gnt    = r_if_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_gnt     = r_d_gnt;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter (MEM_LAT=2, STARVE_MAX=4).
// A transaction-level reference model predicts, for every cycle, the grant,
// strobe, completion and held read data from the arbitration rules and a
// private copy of memory. A small memory model answers the DUT's commands.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int k);
        return (k == 4) ? 32'hDEADBEEF : 32'hA000_0000 + 32'(k) * 32'h111;
    endfunction

    // ---------------- memory model (16 words) ----------------
    logic [31:0] tbmem [16];
    logic [31:0] pipe  [LAT];
    bit          loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int k = 0; k < 16; k++) tbmem[k] <= init_val(k);
            loaded <= 1'b1;
        end else if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) tbmem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        // Junk on idle cycles exposes a capture on the wrong cycle.
        pipe[0] <= (mem_en && !mem_we) ? tbmem[mem_addr[5:2]] : 32'($urandom);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata = pipe[LAT-1];

    // ---------------- reference model ----------------
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [16];
    int          starve = 0;
    bit          rst_fields = 1'b1;
    bit          t_act = 1'b0, t_d = 1'b0, t_we = 1'b0;
    int          t_start = 0;
    logic [31:0] t_addr = '0, t_wdata = '0, t_rdata = '0;
    logic [3:0]  t_be = '0;
    logic [31:0] exp_if_rdata = '0, exp_d_rdata = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endfunction

    // Decide what the arbiter does with the inputs present in cycle cyc.
    function automatic void model_decide();
        bit win_d;
        if (rst) begin
            t_act = 1'b0; starve = 0; rst_fields = 1'b1;
            exp_if_rdata = '0; exp_d_rdata = '0;
            return;
        end
        if (t_act && cyc < t_start + LAT + 2) return;   // busy: requests ignored
        if (!(if_req || d_req)) return;
        win_d = d_req && !(if_req && starve == SMAX);
        if (!win_d) starve = 0;
        else if (if_req && starve < SMAX) starve++;
        t_act = 1'b1; t_start = cyc; t_d = win_d; rst_fields = 1'b0;
        if (win_d) begin
            t_we = d_we; t_addr = d_addr; t_wdata = d_wdata; t_be = d_be;
        end else begin
            t_we = 1'b0; t_addr = if_addr; t_wdata = '0; t_be = 4'hF;
        end
        if (t_we)
            for (int b = 0; b < 4; b++)
                if (t_be[b]) ref_mem[t_addr[5:2]][8*b +: 8] = t_wdata[8*b +: 8];
        t_rdata = ref_mem[t_addr[5:2]];
    endfunction

    // Compare the DUT outputs visible in cycle cyc.
    function automatic void model_check();
        bit g, rv;
        g  = t_act && (cyc == t_start + 1);
        rv = t_act && (cyc == t_start + LAT + 2);
        if (rv && !t_we) begin
            if (t_d) exp_d_rdata = t_rdata;
            else     exp_if_rdata = t_rdata;
        end
        chk("if_gnt",    32'(if_gnt),    32'(g && !t_d));
        chk("d_gnt",     32'(d_gnt),     32'(g && t_d));
        chk("mem_en",    32'(mem_en),    32'(g));
        chk("if_rvalid", 32'(if_rvalid), 32'(rv && !t_d));
        chk("d_rvalid",  32'(d_rvalid),  32'(rv && t_d));
        chk("if_rdata",  if_rdata, exp_if_rdata);
        chk("d_rdata",   d_rdata,  exp_d_rdata);
        if (t_act && cyc >= t_start + 1 && cyc <= t_start + LAT + 1) begin
            chk("mem_addr", mem_addr, t_addr);
            chk("mem_we",   32'(mem_we), 32'(t_we));
            chk("mem_be",   32'(mem_be), 32'(t_be));
            if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
        end else if (rst_fields) begin
            chk("rst_mem_addr",  mem_addr, 32'h0);
            chk("rst_mem_we",    32'(mem_we), 32'h0);
            chk("rst_mem_be",    32'(mem_be), 32'h0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
        end
    endfunction

    task automatic tick();
        model_decide();
        @(posedge clk);
        cyc++;
        #1;
        model_check();
    endtask

    task automatic wait_gnt(output int gcyc);
        for (int n = 0; n < 20; n++) begin
            tick();
            if (if_gnt || d_gnt) break;
        end
        if (!(if_gnt || d_gnt)) chk("gnt_timeout", 32'h0, 32'h1);
        gcyc = cyc;
    endtask

    task automatic wait_rvalid();
        for (int n = 0; n < 20; n++) begin
            tick();
            if (if_rvalid || d_rvalid) break;
        end
        if (!(if_rvalid || d_rvalid)) chk("rvalid_timeout", 32'h0, 32'h1);
    endtask

    function automatic logic [31:0] rand_addr();
        return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          if_req;
        logic [31:0] if_addr;
        bit          d_req;
        bit          d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_be;
        bit          exp_d;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input bit ir, input logic [31:0] ia, input bit dr, input bit we,
                                input logic [31:0] da, input logic [31:0] wd, input logic [3:0] be,
                                input bit ed, input logic [31:0] er);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = we; v.d_addr = da;
        v.d_wdata = wd; v.d_be = be; v.exp_d = ed; v.exp_rdata = er;
        return v;
    endfunction

    vec_t vecs [15];

    initial begin
        int gcyc, last_g, nrv;
        bit ed;
        for (int k = 0; k < 16; k++) ref_mem[k] = init_val(k);

        vecs[0] = mk(1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,    4'h0,    1'b0, 32'hDEADBEEF);
        vecs[1] = mk(1'b0, 32'h0,  1'b1, 1'b1, 32'h20, 32'h1234, 4'b0011, 1'b1, 32'h0);
        vecs[2] = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h20, 32'h0,    4'hF,    1'b1, 32'hA0001234);
        for (int i = 3; i <= 12; i++) begin
            ed = !(i == 7 || i == 12);
            vecs[i] = mk(1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, ed,
                         ed ? 32'hA0000222 : 32'hA0000111);
        end
        vecs[13] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'hC,  32'h0, 4'hF, 1'b1, 32'hA0000333);
        vecs[14] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF, 1'b1, 32'hA0000555);

        // Reset held for 3 cycles with both requests high.
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; if_addr = 32'h4; d_addr = 32'h8;
        repeat (3) tick();
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
        tick();

        // Table: single fetch, write, read-back, priority/starvation, back-to-back.
        last_g = 0;
        for (int i = 0; i < 15; i++) begin
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_addr = vecs[i].d_addr;
            d_wdata = vecs[i].d_wdata; d_be = vecs[i].d_be;
            wait_gnt(gcyc);
            chk("tbl_winner_d", 32'(d_gnt), 32'(vecs[i].exp_d));
            if (i > 0) chk("tbl_gnt_gap", 32'(gcyc - last_g), 32'(LAT + 2));
            last_g = gcyc;
            if (vecs[i].exp_d && vecs[i].d_we) begin
                chk("tbl_mem_we",    32'(mem_we), 32'h1);
                chk("tbl_mem_be",    32'(mem_be), 32'(vecs[i].d_be));
                chk("tbl_mem_wdata", mem_wdata, vecs[i].d_wdata);
            end else begin
                chk("tbl_mem_addr", mem_addr, vecs[i].exp_d ? vecs[i].d_addr : vecs[i].if_addr);
            end
            wait_rvalid();
            chk("tbl_rvalid_d", 32'(d_rvalid), 32'(vecs[i].exp_d));
            if (!(vecs[i].exp_d && vecs[i].d_we))
                chk("tbl_rdata", vecs[i].exp_d ? d_rdata : if_rdata, vecs[i].exp_rdata);
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) tick();

        // Reset in the first WAIT cycle of a read, after building up starvation.
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 32'h4; d_addr = 32'h8;
        repeat (2) begin
            wait_gnt(gcyc);
            chk("pre_rst_win_d", 32'(d_gnt), 32'h1);
            wait_rvalid();
        end
        if_req = 1'b0; d_addr = 32'hC;
        wait_gnt(gcyc);
        tick();
        rst = 1'b1; d_req = 1'b0;
        tick();
        rst = 1'b0;
        nrv = 0;
        repeat (6) begin
            tick();
            if (if_rvalid || d_rvalid) nrv++;
        end
        chk("rst_no_rvalid", 32'(nrv), 32'h0);
        if_req = 1'b1; d_req = 1'b1; d_addr = 32'h8;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(gcyc);
            chk("post_rst_order_d", 32'(d_gnt), 32'(k < 4));
            wait_rvalid();
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) tick();

        // Randomised traffic with occasional resets; requesters hold until granted.
        for (int n = 0; n < 800; n++) begin
            if (!if_req || if_gnt) begin
                if_req = ($urandom_range(0, 2) != 0);
                if_addr = rand_addr();
            end
            if (!d_req || d_gnt) begin
                d_req = ($urandom_range(0, 2) != 0);
                d_we = 1'($urandom_range(0, 1));
                d_addr = rand_addr();
                d_wdata = $urandom;
                d_be = 4'($urandom);
            end
            rst = ($urandom_range(0, 79) == 0);
            tick();
        end
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
        repeat (LAT + 4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
